vmips_vmem_seq: RTL

- Multi-cycle sequencer for vector load/store on the 4-lane VMIPS datapath.
- Accepts one vector memory request from the decode/execute stage.
- Serialises the per-lane element accesses onto a single shared data-memory port, skipping masked lanes.
- Returns the gathered read vector, or write completion, as a one-cycle response pulse; `busy` stalls the PC while the sequencer is active.

---
 rtl/vmips_pkg.sv | 23 ++
 rtl/vmips_lane_pick.sv | 30 +++
 rtl/vmips_vmem_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vmips_pkg.sv
// vmips_pkg: shared types and defaults for the VMIPS vector memory sequencer.
//   state_e  : sequencer FSM state (IDLE, ISSUE, WAIT, DONE), 2 bits.
//   *_DEF    : default lane count, address width and data width.
//   lane_lsb : bit offset of lane i inside a packed LANES*DW vector.
package vmips_pkg;

  localparam int LANES_DEF = 4;
  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Lane i of a packed vector lives at [lane_lsb(i, dw) +: dw].
  function automatic int lane_lsb(input int i, input int dw);
    return i * dw;
  endfunction

endpackage

// File: rtl/vmips_lane_pick.sv
// vmips_lane_pick: combinational priority finder for the next active lane.
//   mask      : lane enables, bit i = lane i.
//   cur       : current lane index.
//   first     : 1 = search from lane 0 (inclusive), 0 = search strictly above cur.
//   nxt       : lowest qualifying set lane (0 when none_left).
//   none_left : no qualifying lane; never wraps back to lane 0.
module vmips_lane_pick #(
  parameter int LANES = 4,
  parameter int IW    = 2
) (
  input  logic [LANES-1:0] mask,
  input  logic [IW-1:0]    cur,
  input  logic             first,
  output logic [IW-1:0]    nxt,
  output logic             none_left
);

  // Scan high to low so the last hit is the lowest qualifying lane.
  always_comb begin
    nxt       = '0;
    none_left = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        nxt       = IW'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vmips_vmem_seq.sv
// vmips_vmem_seq: serialises one vector load/store onto a single shared
// data-memory port, one element at a time, skipping masked lanes.
//
// Optional feature macro: VMEM_STRIDE_EN
//   defined   : req_stride is captured and used as the element increment.
//   undefined : req_stride is ignored, the increment is the constant 1.
//
// Ports:
//   clk, rst               : clock, asynchronous active-low reset.
//   req_valid/req_ready    : request handshake; ready only in IDLE.
//   req_write              : 1 = store, 0 = load.
//   req_base/req_stride    : element-0 address / element increment.
//   req_mask               : lane enables.
//   req_wdata              : store data, lane i at [i*DW +: DW].
//   mem_req/mem_gnt        : memory access request / accept.
//   mem_we/mem_addr/mem_wdata : access attributes, held until gnt.
//   mem_rvalid/mem_rdata   : in-order read return, honoured only in WAIT.
//   rsp_valid              : one-cycle completion pulse.
//   rsp_rdata              : gathered load data, masked lanes read 0.
//   busy                   : high from the accept cycle through rsp_valid.
module vmips_vmem_seq
  import vmips_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AW-1:0]      req_base,
  input  logic [AW-1:0]      req_stride,
  input  logic [LANES-1:0]   req_mask,
  input  logic [LANES*DW-1:0] req_wdata,
  output logic               mem_req,
  input  logic               mem_gnt,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic               mem_rvalid,
  input  logic [DW-1:0]      mem_rdata,
  output logic               rsp_valid,
  output logic [LANES*DW-1:0] rsp_rdata,
  output logic               busy
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  state_e              state, state_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic                write_q;
  logic [AW-1:0]       base_q;
  logic [LANES-1:0]    mask_q;
  logic [LANES*DW-1:0] wdata_q;
  logic [AW-1:0]       stride_eff;
  logic [AW-1:0]       addr_cur;
  logic [AW-1:0]       addr_run;
  logic                accept;

  logic [LANES-1:0]    pick_mask;
  logic                pick_first;
  logic [IW-1:0]       pick_nxt;
  logic                pick_none;

`ifdef VMEM_STRIDE_EN
  logic [AW-1:0] stride_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        stride_q <= '0;
    else if (accept) stride_q <= req_stride;
  end

  assign stride_eff = stride_q;
`else
  logic unused_stride;
  assign unused_stride = ^req_stride;
  assign stride_eff    = {{(AW-1){1'b0}}, 1'b1};
`endif

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // One finder serves both searches: from lane 0 on the incoming mask while
  // idle, and strictly above idx on the captured mask afterwards.
  assign pick_mask  = (state == IDLE) ? req_mask : mask_q;
  assign pick_first = (state == IDLE);

  vmips_lane_pick #(.LANES(LANES), .IW(IW)) u_pick (
    .mask      (pick_mask),
    .cur       (idx),
    .first     (pick_first),
    .nxt       (pick_nxt),
    .none_left (pick_none)
  );

  // Lane address by accumulation: a running sum steps one stride per lane,
  // skipped lanes included, so no multiplier is needed. Wraps mod 2^AW.
  always_comb begin
    addr_run = base_q;
    addr_cur = base_q;
    for (int i = 0; i < LANES; i++) begin
      if (IW'(i) == idx) addr_cur = addr_run;
      addr_run = addr_run + stride_eff;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (accept) begin
          if (pick_none) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ISSUE;
            idx_nxt   = pick_nxt;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          if (!write_q) begin
            state_nxt = WAIT;
          end else if (pick_none) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = pick_nxt;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (pick_none) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ISSUE;
            idx_nxt   = pick_nxt;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      base_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      base_q  <= req_base;
      mask_q  <= req_mask;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
    end else if (accept) begin
      rsp_rdata <= '0;
    end else if ((state == WAIT) && mem_rvalid) begin
      rsp_rdata[lane_lsb(int'(idx), DW) +: DW] <= mem_rdata;
    end
  end

  assign mem_req   = (state == ISSUE);
  assign mem_we    = mem_req & write_q;
  assign mem_addr  = addr_cur;
  assign mem_wdata = wdata_q[lane_lsb(int'(idx), DW) +: DW];
  assign rsp_valid = (state == DONE);
  // accept term makes busy rise in the accept cycle itself.
  assign busy      = accept | (state != IDLE);

endmodule
